// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one register slice between adjacent pipeline stages.
// Carries a control bundle, a data bundle, a valid bit and a debug PC.
// Supports hazard-unit stall (hold) and flush (bubble insert).
// Keeps saturating stall and bubble counters for trace/debug.
// The slice is either EMPTY (valid_o=0) or FULL (valid_o=1).
// All outputs are driven straight from flops.

module pipe_stage_reg #(
    parameter int                CTRL_W   = 8,
    parameter int                DATA_W   = 96,
    parameter int                CNT_W    = 16,
    parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    input  logic [31:0]       debug_pc_i,
    input  logic              cnt_clr,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic [31:0]       debug_pc_o,
    output logic              debug_have_inst_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // A stall is only worth counting when it actually holds a real instruction.
    logic stall_event;
    logic stall_inc;
    logic bubble_inc;

    // Qualify counter increments; saturation is folded in so counters never wrap.
    always_comb begin
        stall_event = stall && !flush && valid_o;
        stall_inc   = stall_event && (stall_cnt_o != CNT_MAX);
        bubble_inc  = flush && (bubble_cnt_o != CNT_MAX);
    end

    // Pipeline payload: reset beats flush, flush beats stall, otherwise load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_o     <= CTRL_RST;
            data_o     <= '0;
            valid_o    <= 1'b0;
            debug_pc_o <= '0;
        end else if (flush) begin
            ctrl_o     <= CTRL_RST;
            data_o     <= '0;
            valid_o    <= 1'b0;
            debug_pc_o <= '0;
        end else if (!stall) begin
            ctrl_o     <= ctrl_i;
            data_o     <= data_i;
            valid_o    <= valid_i;
            debug_pc_o <= debug_pc_i;
        end
    end

    // Trace commit qualifier: its own flop tracking the same next-state as valid_o.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            debug_have_inst_o <= 1'b0;
        end else if (flush) begin
            debug_have_inst_o <= 1'b0;
        end else if (!stall) begin
            debug_have_inst_o <= valid_i;
        end
    end

    // Stall counter: clear wins over increment, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (cnt_clr) begin
            stall_cnt_o <= '0;
        end else if (stall_inc) begin
            stall_cnt_o <= stall_cnt_o + CNT_ONE;
        end
    end

    // Bubble counter: counts every flush cycle, clear wins, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_o <= '0;
        end else if (cnt_clr) begin
            bubble_cnt_o <= '0;
        end else if (bubble_inc) begin
            bubble_cnt_o <= bubble_cnt_o + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vectors with hand-computed expectations.
// Uses a narrow counter width so saturation is reachable quickly.
// Uses a non-zero CTRL_RST so bubbles are distinguishable from zero control.

module tb_pipe_stage_reg;

    localparam int             CTRL_W   = 8;
    localparam int             DATA_W   = 96;
    localparam int             CNT_W    = 4;
    localparam logic [7:0]     CTRL_RST = 8'h81;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              flush;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic [31:0]       debug_pc_i;
    logic              cnt_clr;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic [31:0]       debug_pc_o;
    logic              debug_have_inst_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    int total;
    int bad;

    logic [DATA_W-1:0] pat_a5;
    logic [DATA_W-1:0] pat_b;

    pipe_stage_reg #(
        .CTRL_W  (CTRL_W),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W),
        .CTRL_RST(CTRL_RST)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .flush            (flush),
        .ctrl_i           (ctrl_i),
        .data_i           (data_i),
        .valid_i          (valid_i),
        .debug_pc_i       (debug_pc_i),
        .cnt_clr          (cnt_clr),
        .ctrl_o           (ctrl_o),
        .data_o           (data_o),
        .valid_o          (valid_o),
        .debug_pc_o       (debug_pc_o),
        .debug_have_inst_o(debug_have_inst_o),
        .stall_cnt_o      (stall_cnt_o),
        .bubble_cnt_o     (bubble_cnt_o)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and tally the result.
    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, take one posedge, then settle just after it.
    task automatic applyStimulus(input logic rst_v, input logic stall_v, input logic flush_v,
                                 input logic clr_v, input logic valid_v, input logic [7:0] ctrl_v,
                                 input logic [DATA_W-1:0] data_v, input logic [31:0] pc_v);
        rst_n      = rst_v;
        stall      = stall_v;
        flush      = flush_v;
        cnt_clr    = clr_v;
        valid_i    = valid_v;
        ctrl_i     = ctrl_v;
        data_i     = data_v;
        debug_pc_i = pc_v;
        @(posedge clk);
        #1;
    endtask

    // Directed test sequence.
    initial begin
        total  = 0;
        bad    = 0;
        pat_a5 = {12{8'hA5}};
        pat_b  = 96'h0000_1234_0000_5678_0000_9ABC;

        // Reset held two edges with stall and valid_i asserted.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, pat_a5, 32'h1000);
        checkOutput("rst_ctrl",   ctrl_o, CTRL_RST);
        checkOutput("rst_data",   data_o, 0);
        checkOutput("rst_valid",  valid_o, 0);
        checkOutput("rst_pc",     debug_pc_o, 0);
        checkOutput("rst_have",   debug_have_inst_o, 0);
        checkOutput("rst_scnt",   stall_cnt_o, 0);
        checkOutput("rst_bcnt",   bubble_cnt_o, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, pat_a5, 32'h1000);
        checkOutput("rst2_valid", valid_o, 0);

        // Load.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, pat_a5, 32'h1000);
        checkOutput("ld_ctrl",  ctrl_o, 8'h3C);
        checkOutput("ld_data",  data_o, pat_a5);
        checkOutput("ld_valid", valid_o, 1);
        checkOutput("ld_have",  debug_have_inst_o, 1);
        checkOutput("ld_pc",    debug_pc_o, 32'h1000);

        // Stall for three cycles with new inputs presented.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, pat_b, 32'h1004);
        checkOutput("st_ctrl",  ctrl_o, 8'h3C);
        checkOutput("st_data",  data_o, pat_a5);
        checkOutput("st_pc",    debug_pc_o, 32'h1000);
        checkOutput("st_valid", valid_o, 1);
        checkOutput("st_scnt",  stall_cnt_o, 3);
        checkOutput("st_bcnt",  bubble_cnt_o, 0);

        // Release stall.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, pat_b, 32'h1004);
        checkOutput("rel_pc",   debug_pc_o, 32'h1004);
        checkOutput("rel_ctrl", ctrl_o, 8'h55);
        checkOutput("rel_data", data_o, pat_b);
        checkOutput("rel_scnt", stall_cnt_o, 3);

        // Flush together with stall on a full stage.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h66, pat_a5, 32'h1008);
        checkOutput("fl_valid", valid_o, 0);
        checkOutput("fl_have",  debug_have_inst_o, 0);
        checkOutput("fl_ctrl",  ctrl_o, CTRL_RST);
        checkOutput("fl_data",  data_o, 0);
        checkOutput("fl_pc",    debug_pc_o, 0);
        checkOutput("fl_bcnt",  bubble_cnt_o, 1);
        checkOutput("fl_scnt",  stall_cnt_o, 3);

        // Stall on an empty stage is not counted.
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h66, pat_a5, 32'h1008);
        checkOutput("es_scnt",  stall_cnt_o, 3);
        checkOutput("es_valid", valid_o, 0);
        checkOutput("es_ctrl",  ctrl_o, CTRL_RST);

        // Invalid input loads ctrl unchanged but leaves the stage empty.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7E, pat_b, 32'h2000);
        checkOutput("inv_ctrl",  ctrl_o, 8'h7E);
        checkOutput("inv_valid", valid_o, 0);
        checkOutput("inv_have",  debug_have_inst_o, 0);
        checkOutput("inv_pc",    debug_pc_o, 32'h2000);

        // Flush repeatedly: counter climbs from 1 to 15 and then saturates.
        for (int i = 0; i < 14; i++)
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, pat_b, 32'h2000);
        checkOutput("sat_bcnt14", bubble_cnt_o, 15);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, pat_b, 32'h2000);
        checkOutput("sat_bcnt20", bubble_cnt_o, 15);
        checkOutput("sat_scnt",   stall_cnt_o, 3);

        // Clear together with flush: clear wins.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, pat_b, 32'h2000);
        checkOutput("clr_bcnt", bubble_cnt_o, 0);
        checkOutput("clr_scnt", stall_cnt_o, 0);

        // Clear alone does not disturb the pipeline payload.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h42, pat_a5, 32'h3000);
        checkOutput("clrld_valid", valid_o, 1);
        checkOutput("clrld_pc",    debug_pc_o, 32'h3000);
        checkOutput("clrld_ctrl",  ctrl_o, 8'h42);

        // One counted stall, then reset asserted mid-cycle: no change until the edge.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h99, pat_b, 32'h3004);
        checkOutput("pre_scnt", stall_cnt_o, 1);
        rst_n = 1'b0;
        #2;
        checkOutput("async_valid", valid_o, 1);
        checkOutput("async_pc",    debug_pc_o, 32'h3000);
        checkOutput("async_scnt",  stall_cnt_o, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h99, pat_b, 32'h3004);
        checkOutput("srst_valid", valid_o, 0);
        checkOutput("srst_ctrl",  ctrl_o, CTRL_RST);
        checkOutput("srst_pc",    debug_pc_o, 0);
        checkOutput("srst_scnt",  stall_cnt_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
